// File: rtl/cpu_wb_pkg.sv
// Shared constants and request type for the write-back arbiter and scoreboard.
package cpu_wb_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int NREG = 1 << RAW;

  typedef struct packed {
    logic            vld;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/cpu_wb_scoreboard.sv
// Pending-destination scoreboard: set on issue, cleared on register-file write.
module cpu_wb_scoreboard
  import cpu_wb_pkg::*;
#(
  parameter int RAW = cpu_wb_pkg::RAW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           iss_en,
  input  logic [RAW-1:0] iss_rd,
  output logic           iss_ok,
  input  logic [RAW-1:0] rs1,
  input  logic [RAW-1:0] rs2,
  output logic           busy1,
  output logic           busy2,
  input  logic           wr_en,
  input  logic [RAW-1:0] rd
);

  localparam int N = 1 << RAW;

  logic [N-1:0] pending;
  logic [N-1:0] pending_nxt;

  // Clear is applied before set so a same-cycle set on the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (wr_en)
      pending_nxt[rd] = 1'b0;
    if (iss_en && (iss_rd != '0))
      pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  assign busy1  = pending[rs1] && (rs1 != '0);
  assign busy2  = pending[rs2] && (rs2 != '0);
  assign iss_ok = !(pending[iss_rd] && (iss_rd != '0));

endmodule

// File: rtl/cpu_wb_arb.sv
// Write-back arbiter: round-robin merge of ALU and LSU results onto the
// register-file write port, plus commit counter and hazard scoreboard.
module cpu_wb_arb
  import cpu_wb_pkg::*;
#(
  parameter int XLEN = cpu_wb_pkg::XLEN,
  parameter int RAW  = cpu_wb_pkg::RAW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_en,
  input  logic [RAW-1:0]  iss_rd,
  output logic            iss_ok,
  input  logic [RAW-1:0]  rs1,
  input  logic [RAW-1:0]  rs2,
  output logic            busy1,
  output logic            busy2,
  input  logic            alu_vld,
  output logic            alu_rdy,
  input  logic [RAW-1:0]  alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_vld,
  output logic            lsu_rdy,
  input  logic [RAW-1:0]  lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wr_en,
  output logic [RAW-1:0]  rd,
  output logic [XLEN-1:0] data_rd,
  output logic [31:0]     wb_cnt
);

  wb_req_t alu_req;
  wb_req_t lsu_req;
  wb_req_t gnt_req;
  logic    last;
  logic    xfer;

  assign alu_req = '{vld: alu_vld, rd: alu_rd, data: alu_data};
  assign lsu_req = '{vld: lsu_vld, rd: lsu_rd, data: lsu_data};

  // last: 0 = ALU granted last, 1 = LSU granted last.
  always_comb begin
    alu_rdy = 1'b0;
    lsu_rdy = 1'b0;
    gnt_req = '0;
    if (!rst) begin
      if (alu_req.vld && (!lsu_req.vld || last)) begin
        alu_rdy = 1'b1;
        gnt_req = alu_req;
      end else if (lsu_req.vld) begin
        lsu_rdy = 1'b1;
        gnt_req = lsu_req;
      end
    end
  end

  assign xfer = alu_rdy || lsu_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      rd      <= '0;
      data_rd <= '0;
      last    <= 1'b1;
      wb_cnt  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (xfer) begin
        // x0 destinations are consumed but never reach the register file.
        wr_en   <= (gnt_req.rd != '0);
        rd      <= gnt_req.rd;
        data_rd <= gnt_req.data;
        last    <= lsu_rdy;
      end
      if (wr_en)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end

  cpu_wb_scoreboard #(.RAW(RAW)) u_sb (
    .clk    (clk),
    .rst    (rst),
    .iss_en (iss_en),
    .iss_rd (iss_rd),
    .iss_ok (iss_ok),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy1  (busy1),
    .busy2  (busy2),
    .wr_en  (wr_en),
    .rd     (rd)
  );

endmodule
